// File: rtl/gsr_pkg.sv
// Shared types and helpers for the game-state RAM: FSM states, default sizing
// and the word indices of the per-player status words.
package gsr_pkg;

    typedef enum logic {
        GSR_IDLE  = 1'b0,
        GSR_CLEAR = 1'b1
    } gsr_state_t;

    localparam int N_PLAYERS_DEF = 2;
    localparam int DEPTH_DEF     = 1024;
    localparam int STATUS_WORDS  = 2 * N_PLAYERS_DEF;
    localparam int ADDR_W        = $clog2(DEPTH_DEF);

    // Lives words occupy 0..N-1, door words follow at N..2N-1.
    function automatic int lives_word(input int p);
        return p;
    endfunction

    function automatic int doors_word(input int n_players, input int p);
        return n_players + p;
    endfunction

endpackage

// File: rtl/gsr_clear_engine.sv
// Sweep engine that zeroes every word of the game-state RAM after reset or on
// request; while it runs it owns the memory write port and raises busy.
module gsr_clear_engine
    import gsr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [AW-1:0]     clr_addr,
    output logic [DATA_W-1:0] clr_wd
);

    gsr_state_t    state, state_nx;
    logic [AW-1:0] ptr, ptr_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= GSR_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        busy     = 1'b0;
        clr_we   = 1'b0;
        case (state)
            GSR_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (ptr == AW'(DEPTH - 1)) begin
                    state_nx = GSR_IDLE;
                    ptr_nx   = '0;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
            default: begin
                // A request arriving mid-sweep is ignored by construction.
                if (clr_req) begin
                    state_nx = GSR_CLEAR;
                    ptr_nx   = '0;
                end
            end
        endcase
    end

    assign clr_addr = ptr;
    assign clr_wd   = '0;

endmodule

// File: rtl/game_state_ram.sv
// Game-state RAM: byte-enable CPU port, registered read, hardware clear, and
// lives/doors mirrors. Define GSR_VSYNC_LATCH_EN to latch mirrors on vsync.
module game_state_ram
    import gsr_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int N_PLAYERS = 2,
    parameter int LIVES_W   = 2,
    parameter int DOOR_W    = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [31:0]                   addr,
    input  logic [DATA_W-1:0]             WD,
    input  logic                          WE,
    input  logic [DATA_W/8-1:0]           BE,
    input  logic                          RE,
    output logic [DATA_W-1:0]             RD,
    output logic                          rd_valid,
    output logic                          addr_err,
    input  logic                          clr_req,
    output logic                          busy,
    input  logic                          vsync,
    output logic [N_PLAYERS*LIVES_W-1:0]  lives,
    output logic [N_PLAYERS*DOOR_W-1:0]   doors
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    logic              clr_we;
    logic [AW-1:0]     clr_addr;
    logic [DATA_W-1:0] clr_wd;

    gsr_clear_engine #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_clear (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_wd   (clr_wd)
    );

    logic              in_range, accept, cpu_we;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [NB-1:0]     mem_be;

    assign in_range = (addr < 32'(DEPTH));
    assign accept   = !busy;
    // A clear request in the same cycle pre-empts the CPU write.
    assign cpu_we   = accept && WE && in_range && !clr_req;

    assign mem_we   = busy ? clr_we   : cpu_we;
    assign mem_addr = busy ? clr_addr : addr[AW-1:0];
    assign mem_wd   = busy ? clr_wd   : WD;
    assign mem_be   = busy ? '1       : BE;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
    end

    // Stage p0 -> p1: registered read port and access status
    logic [DATA_W-1:0] rd_p1;
    logic              vld_p1, err_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_p1  <= '0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept && RE;
            err_p1 <= accept && (WE || RE) && !in_range;
            if (accept && RE) rd_p1 <= in_range ? mem[addr[AW-1:0]] : '0;
        end
    end

    assign RD       = rd_p1;
    assign rd_valid = vld_p1;
    assign addr_err = err_p1;

    logic [N_PLAYERS*LIVES_W-1:0] lives_sh, lives_nx;
    logic [N_PLAYERS*DOOR_W-1:0]  doors_sh, doors_nx;

    always_comb begin
        lives_nx = lives_sh;
        doors_nx = doors_sh;
        if (mem_we) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                if (mem_addr == AW'(lives_word(p))) begin
                    for (int b = 0; b < LIVES_W; b++) begin
                        if (mem_be[b/8]) lives_nx[p*LIVES_W + b] = mem_wd[b];
                    end
                end
                if (mem_addr == AW'(doors_word(N_PLAYERS, p))) begin
                    for (int b = 0; b < DOOR_W; b++) begin
                        if (mem_be[b/8]) doors_nx[p*DOOR_W + b] = mem_wd[b];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lives_sh <= '0;
            doors_sh <= '0;
        end else begin
            lives_sh <= lives_nx;
            doors_sh <= doors_nx;
        end
    end

`ifdef GSR_VSYNC_LATCH_EN
    logic [N_PLAYERS*LIVES_W-1:0] lives_q;
    logic [N_PLAYERS*DOOR_W-1:0]  doors_q;

    // Outputs only change at frame boundaries so a frame never shows a mix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lives_q <= '0;
            doors_q <= '0;
        end else if (vsync) begin
            lives_q <= lives_sh;
            doors_q <= doors_sh;
        end
    end

    assign lives = lives_q;
    assign doors = doors_q;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign lives = lives_sh;
    assign doors = doors_sh;
`endif

endmodule

// File: tb/tb_game_state_ram.sv
// Randomized bench for game_state_ram against a word-array reference model;
// honours GSR_VSYNC_LATCH_EN when the build defines it.
module tb_game_state_ram;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr, WD, RD;
    logic        WE, RE, rd_valid, addr_err, clr_req, busy, vsync;
    logic [3:0]  BE, lives, doors;

    game_state_ram #(
        .DATA_W (32), .DEPTH (DEPTH), .N_PLAYERS (2), .LIVES_W (2), .DOOR_W (2)
    ) dut (
        .clk (clk), .reset_n (reset_n), .addr (addr), .WD (WD), .WE (WE),
        .BE (BE), .RE (RE), .RD (RD), .rd_valid (rd_valid), .addr_err (addr_err),
        .clr_req (clr_req), .busy (busy), .vsync (vsync), .lives (lives),
        .doors (doors)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: memory contents, remaining clear cycles, expected outputs.
    logic [31:0] mem_m [DEPTH];
    int          clear_left;
    logic [31:0] exp_rd;
    logic        exp_vld, exp_err;
    logic [3:0]  exp_lives, exp_doors;

    function automatic logic [3:0] lives_now();
        return {mem_m[1][1:0], mem_m[0][1:0]};
    endfunction

    function automatic logic [3:0] doors_now();
        return {mem_m[3][1:0], mem_m[2][1:0]};
    endfunction

    task automatic model_edge(input logic we, re, clr, vs, input logic [31:0] a, wd,
                              input logic [3:0] be);
        logic [3:0] pre_l, pre_d;
        pre_l = lives_now();
        pre_d = doors_now();
        if (clear_left > 0) begin
            mem_m[DEPTH - clear_left] = '0;
            clear_left--;
            exp_vld = 1'b0;
            exp_err = 1'b0;
        end else begin
            exp_vld = re;
            exp_err = (we || re) && (a >= DEPTH);
            if (re) exp_rd = (a < DEPTH) ? mem_m[a] : '0;
            if (clr) clear_left = DEPTH;
            else if (we && a < DEPTH)
                for (int i = 0; i < 4; i++) if (be[i]) mem_m[a][8*i +: 8] = wd[8*i +: 8];
        end
`ifdef GSR_VSYNC_LATCH_EN
        if (vs) begin
            exp_lives = pre_l;
            exp_doors = pre_d;
        end
`else
        exp_lives = lives_now();
        exp_doors = doors_now();
`endif
    endtask

    task automatic compare_all();
        check("busy", busy, clear_left > 0);
        check("rd_valid", rd_valid, exp_vld);
        check("addr_err", addr_err, exp_err);
        check("rd", RD, exp_rd);
        check("lives", lives, exp_lives);
        check("doors", doors, exp_doors);
    endtask

    task automatic step(input logic we, re, clr, vs, input logic [31:0] a, wd,
                        input logic [3:0] be);
        WE = we; RE = re; clr_req = clr; vsync = vs; addr = a; WD = wd; BE = be;
        model_edge(we, re, clr, vs, a, wd, be);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic vs);
        step(1'b0, 1'b0, 1'b0, vs, 32'd0, 32'd0, 4'h0);
    endtask

    // The sweep zeroes everything before any access can be accepted, so the
    // model treats the array (and hence the mirrors) as zero from reset.
    task automatic apply_reset();
        WE = 0; RE = 0; clr_req = 0; vsync = 0; addr = 0; WD = 0; BE = 0;
        reset_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        clear_left = DEPTH;
        exp_rd = '0; exp_vld = 0; exp_err = 0; exp_lives = '0; exp_doors = '0;
        @(posedge clk);
        #1;
        check("rst_rd", RD, 32'd0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_err", addr_err, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_lives", lives, 4'd0);
        check("rst_doors", doors, 4'd0);
        reset_n = 1'b1;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            idle(1'b0);
            n++;
        end
        check(tag, n, DEPTH);
    endtask

    initial begin
        reset_n = 1'b0;
        apply_reset();
        count_busy("clear_len_reset");

        step(0, 1, 0, 0, 32'd1023, 32'd0, 4'h0);
        check("rd_1023", RD, 32'd0);
        check("rd_1023_vld", rd_valid, 1'b1);

        step(1, 0, 0, 0, 32'd10, 32'h1122_3344, 4'hF);
        step(1, 0, 0, 0, 32'd10, 32'hAABB_CCDD, 4'b0101);
        step(0, 1, 0, 0, 32'd10, 32'd0, 4'h0);
        check("be_merge", RD, 32'h11BB_33DD);

        step(1, 0, 0, 0, 32'd0, 32'd3, 4'hF);
        step(1, 0, 0, 0, 32'd3, 32'd2, 4'hF);
`ifndef GSR_VSYNC_LATCH_EN
        check("lives_p0", lives[1:0], 2'd3);
        check("doors_p1", doors[3:2], 2'd2);
`endif
        step(1, 0, 0, 0, 32'd1, 32'd1, 4'hF);
`ifdef GSR_VSYNC_LATCH_EN
        check("lives_p1_hold", lives[3:2], 2'd0);
        idle(1'b0);
        check("lives_p1_hold2", lives[3:2], 2'd0);
`else
        check("lives_p1", lives[3:2], 2'd1);
`endif
        idle(1'b1);
        check("lives_p1_vs", lives[3:2], 2'd1);
        check("lives_p0_vs", lives[1:0], 2'd3);
        check("doors_p1_vs", doors[3:2], 2'd2);

        step(1, 0, 0, 0, 32'd1024, 32'hFFFF_FFFF, 4'hF);
        check("oor_we_err", addr_err, 1'b1);
        step(0, 1, 0, 0, 32'd0, 32'd0, 4'h0);
        check("oor_err_pulse", addr_err, 1'b0);
        check("mem0_kept", RD, 32'd3);
        step(0, 1, 0, 0, 32'd2000, 32'd0, 4'h0);
        check("oor_rd", RD, 32'd0);
        check("oor_rd_vld", rd_valid, 1'b1);

        step(1, 0, 0, 0, 32'd5, 32'h1234_5678, 4'hF);
        step(1, 0, 1, 0, 32'd5, 32'hDEAD_BEEF, 4'hF);
        count_busy("clear_len_req");
        step(0, 1, 0, 0, 32'd5, 32'd0, 4'h0);
        check("collision_rd5", RD, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = $urandom_range(0, 7);
                5:             a = $urandom_range(DEPTH - 8, DEPTH - 1);
                6, 9:          a = $urandom_range(0, DEPTH - 1);
                7:             a = $urandom_range(DEPTH, 4095);
                default:       a = 32'hFFFF_FFFF;
            endcase
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0,
                 a, $urandom, 4'($urandom));
        end
        while (busy === 1'b1 && clear_left > 0) idle(1'b0);

        for (int i = 0; i < 100; i++) idle(1'b0);
        step(0, 0, 1, 0, 32'd0, 32'd0, 4'h0);
        for (int i = 0; i < 100; i++) idle(1'b0);
        apply_reset();
        count_busy("clear_len_midreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_state_ram.md
# game_state_ram

Parametrised game-state video RAM: a single-port word memory that the CPU reads and writes, with the low words mirrored to per-player lives and correct-door outputs for the display and game logic. It adds byte-enable writes, a registered read with a valid strobe, and out-of-range detection. A hardware clear engine zeroes the whole array after reset or on request. It sits on the CPU data bus beside data memory and feeds the video and game-control logic.

## Interface
- DATA_W, 32, word width; multiple of 8
- DEPTH, 1024, number of words
- N_PLAYERS, 2, players; status region is words 0..2*N_PLAYERS-1
- LIVES_W, 2, lives field width (bits [LIVES_W-1:0] of word p)
- DOOR_W, 2, door field width (bits [DOOR_W-1:0] of word N_PLAYERS+p)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- addr  in  32  word index; valid range 0..DEPTH-1
- WD  in  DATA_W  write data
- WE  in  1  write strobe
- BE  in  DATA_W/8  byte enables; bit i gates WD[8i+7:8i]
- RE  in  1  read strobe
- RD  out  DATA_W  read data, registered
- rd_valid  out  1  RD is valid this cycle
- addr_err  out  1  one-cycle pulse for a WE or RE with addr >= DEPTH
- clr_req  in  1  pulse that requests a full clear
- busy  out  1  clear engine active
- vsync  in  1  frame-boundary pulse (used only with the macro)
- lives  out  N_PLAYERS*LIVES_W  player p at [p*LIVES_W +: LIVES_W]
- doors  out  N_PLAYERS*DOOR_W  player p at [p*DOOR_W +: DOOR_W]

## Operation
- FSM states: CLEAR, IDLE. Asynchronous reset sends the FSM to CLEAR with the sweep pointer at 0. CLEAR writes 0 to word ptr each cycle and increments ptr. When ptr = DEPTH-1 it moves to IDLE.
- While in IDLE, clr_req=1 moves the FSM to CLEAR with ptr=0.
- busy=1 in CLEAR. In CLEAR, WE and RE are ignored: no write, no rd_valid, no addr_err.
- Write (IDLE, WE=1, addr<DEPTH): each byte lane with BE[i]=1 is updated. Lanes with BE[i]=0 keep their value.
- Read (IDLE, RE=1, addr<DEPTH): RD holds mem[addr] on the next cycle and rd_valid=1. Read-during-write to the same address returns the old data.
- Out of range: the write is dropped. A read gives rd_valid=1 with RD=0. addr_err pulses on the next cycle.
- WE and RE together: both are performed.
- clr_req together with WE in IDLE: the clear wins and the write is dropped.
- The status shadow registers track the low LIVES_W/DOOR_W bits of the status words, including writes made by the clear engine.

## Timing
- Reset values: RD=0, rd_valid=0, addr_err=0, busy=1, lives=0, doors=0. The array content is undefined until the sweep finishes.
- Clear takes DEPTH cycles. busy falls on the edge after the write to word DEPTH-1.
- The first access is accepted in the first cycle with busy=0.
- Read latency is 1 cycle. Each rd_valid is a single-cycle pulse.
- Shadow update: in the same edge as the write to the status word.
- reset_n asserted mid-clear restarts the sweep from 0.
- clr_req during CLEAR is ignored. It does not extend the sweep.

## Configuration
- GSR_VSYNC_LATCH_EN defined:
  - lives and doors are copied from the shadows only on a clk edge with vsync=1. This prevents tearing within a frame.
  - The clear engine still zeroes the shadows. The outputs only reach 0 at the next vsync.
- GSR_VSYNC_LATCH_EN undefined:
  - lives and doors equal the shadows directly, with one edge of latency after the write.
  - vsync is ignored.

## Structure
- Package gsr_pkg holds:
  - the FSM state enum (GSR_IDLE, GSR_CLEAR)
  - localparams STATUS_WORDS = 2*N_PLAYERS and ADDR_W = $clog2(DEPTH)
  - helper functions for the lives and doors word indices
- One sub-module, gsr_clear_engine, holds the FSM, the sweep pointer and busy. It supplies the write address, data and enable that the top multiplexes ahead of the CPU port.

## Test plan
- Clear after reset: release reset_n -> busy=1 for exactly 1024 cycles. A read of addr 1023 after that gives RD=0 with rd_valid one cycle later.
- Byte enables: write 0x11223344 with BE=4'hF, then 0xAABBCCDD with BE=4'b0101 to addr 10. A read then returns 0x11BB33DD.
- Status mirror (macro off): write 3 to addr 0 and 2 to addr 3 -> lives[1:0]=3 and doors[3:2]=2 one edge later.
- Vsync latch (macro on): write 1 to addr 1 -> lives[3:2] stays 0 until the vsync pulse, then becomes 1.
- Out of range: WE at addr 1024 -> addr_err pulses once and mem[0] is unchanged. RE at addr 2000 -> RD=0 and rd_valid=1.
- Clear collision: write to addr 5 and clr_req in the same cycle -> the write is dropped and busy runs 1024 cycles. Reset asserted mid-sweep restarts busy for the full 1024 cycles.
